// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: resolves jump, load-use and multi-cycle stalls into per-stage hold/flush.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned AW        = 32,
  parameter int unsigned FLUSH_CYC = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [AW-1:0]    jump_addr_i,
  input  logic             load_use_i,
  input  logic             mc_req_i,
  input  logic             mc_done_i,
  output logic             pc_jump_en_o,
  output logic [AW-1:0]    pc_jump_addr_o,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs are forced low while rst is high, even if a request input is active.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    pc_jump_en_o   = 1'b0;
    pc_jump_addr_o = '0;
    pc_hold_o      = 1'b0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    if (!rst) begin
      if (jump_en_i) begin
        pc_jump_en_o   = 1'b1;
        pc_jump_addr_o = jump_addr_i;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        state_next     = (FLUSH_CYC > 0) ? FLUSH : RUN;
        cnt_next       = 3'(FLUSH_CYC);
      end else begin
        case (state)
          FLUSH: begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_next      = cnt - 3'd1;
            if (cnt <= 3'd1) state_next = RUN;
          end
          MC_WAIT: begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
            if (mc_done_i) state_next = RUN;
          end
          RUN: begin
            if (mc_req_i) begin
              pc_hold_o     = 1'b1;
              if_id_hold_o  = 1'b1;
              id_ex_flush_o = 1'b1;
              if (!mc_done_i) state_next = MC_WAIT;
            end else if (load_use_i) begin
              pc_hold_o     = 1'b1;
              if_id_hold_o  = 1'b1;
              id_ex_flush_o = 1'b1;
            end
          end
          default: state_next = RUN;
        endcase
      end
    end
  end

  assign state_o = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold_o) stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_ex_flush_o && !pc_hold_o) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
